// File: rtl/cache_req_sequencer.sv
// cache_req_sequencer: programmable request sequencer that drives the CPU side
// of a cache under test. A DEPTH-entry program is replayed in order; each
// request advances only on a hit, read data is compared against the entry's
// expected value, and a run aborts when one request stalls for too long.
// Optional feature: define SEQ_LOOP_EN to replay the program continuously
// until a stop (start during a run) or a stall timeout.
module cache_req_sequencer #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 64,
  localparam int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              prog_we,
  input  logic [IDX_W-1:0]  prog_idx,
  input  logic              prog_rw,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_wdata,
  input  logic              prog_chk,
  input  logic [DATA_W-1:0] prog_expect,
  input  logic [IDX_W:0]    prog_len,
  input  logic              start,
  input  logic              hit_miss,
  input  logic [DATA_W-1:0] Read_Data,
  output logic              req_valid,
  output logic              read_write,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] write_data,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [7:0]        err_count,
  output logic [IDX_W-1:0]  first_err_idx,
  output logic              err_valid,
  output logic [7:0]        pass_count
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);

`ifdef SEQ_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q;
  logic [IDX_W-1:0]  idx_q;
  logic [IDX_W:0]    len_q;
  logic [WAIT_W-1:0] wait_q;
  logic              done_q;
  logic              timeout_q;
  logic [7:0]        err_cnt_q;
  logic [IDX_W-1:0]  first_err_q;
  logic              err_valid_q;
  logic [7:0]        pass_q;

  logic              mem_rw_q    [DEPTH];
  logic [ADDR_W-1:0] mem_addr_q  [DEPTH];
  logic [DATA_W-1:0] mem_wdata_q [DEPTH];
  logic              mem_chk_q   [DEPTH];
  logic [DATA_W-1:0] mem_exp_q   [DEPTH];

  logic run_d;
  logic stall_out_d;
  logic stop_d;
  logic mismatch_d;
  logic last_d;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Decode of the current request: abort/stop conditions, compare result, last entry
  always_comb begin
    run_d       = (state_q == RUN);
    stall_out_d = run_d && (wait_q == WAIT_W'(TIMEOUT));
    stop_d      = LOOP && run_d && start;
    mismatch_d  = !mem_rw_q[idx_q] && mem_chk_q[idx_q] &&
                  (Read_Data != mem_exp_q[idx_q]);
    last_d      = ({1'b0, idx_q} == (len_q - (IDX_W + 1)'(1)));
  end

  // Program memory: loadable only while no run is active; never cleared by reset
  always_ff @(posedge clock) begin
    if (prog_we && !run_d) begin
      mem_rw_q[prog_idx]    <= prog_rw;
      mem_addr_q[prog_idx]  <= prog_addr;
      mem_wdata_q[prog_idx] <= prog_wdata;
      mem_chk_q[prog_idx]   <= prog_chk;
      mem_exp_q[prog_idx]   <= prog_expect;
    end
  end

  // Run-control FSM with status/statistics registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      len_q       <= '0;
      wait_q      <= '0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      err_cnt_q   <= '0;
      first_err_q <= '0;
      err_valid_q <= 1'b0;
      pass_q      <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            len_q       <= prog_len;
            idx_q       <= '0;
            wait_q      <= '0;
            timeout_q   <= 1'b0;
            err_cnt_q   <= '0;
            first_err_q <= '0;
            err_valid_q <= 1'b0;
            if (prog_len == '0) begin
              // Empty program: complete immediately without issuing anything
              state_q <= DONE;
              done_q  <= 1'b1;
              pass_q  <= LOOP ? 8'd0 : 8'd1;
            end else begin
              state_q <= RUN;
              done_q  <= 1'b0;
              pass_q  <= '0;
            end
          end
        end
        RUN: begin
          if (stop_d) begin
            state_q   <= DONE;
            done_q    <= 1'b1;
            timeout_q <= 1'b0;
          end else if (stall_out_d) begin
            // Stall budget exhausted: abort, idx keeps the stalled entry
            state_q   <= DONE;
            done_q    <= 1'b1;
            timeout_q <= 1'b1;
          end else if (hit_miss) begin
            wait_q <= '0;
            if (mismatch_d) begin
              err_cnt_q <= sat_inc8(err_cnt_q);
              if (!err_valid_q) begin
                err_valid_q <= 1'b1;
                first_err_q <= idx_q;
              end
            end
            if (last_d) begin
              if (LOOP) begin
                idx_q  <= '0;
                pass_q <= sat_inc8(pass_q);
              end else begin
                state_q <= DONE;
                done_q  <= 1'b1;
                pass_q  <= 8'd1;
              end
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end else begin
            wait_q <= wait_q + WAIT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Request outputs mirror the current entry only while running
  always_comb begin
    req_valid  = run_d;
    busy       = run_d;
    read_write = run_d ? mem_rw_q[idx_q]    : 1'b0;
    address    = run_d ? mem_addr_q[idx_q]  : '0;
    write_data = run_d ? mem_wdata_q[idx_q] : '0;
  end

  assign done          = done_q;
  assign timeout       = timeout_q;
  assign err_count     = err_cnt_q;
  assign first_err_idx = first_err_q;
  assign err_valid     = err_valid_q;
  assign pass_count    = pass_q;

endmodule

// File: tb/tb_cache_req_sequencer.sv
// Self-checking bench for cache_req_sequencer: directed scenarios with literal
// expectations plus a randomized phase, all compared every cycle against a
// behavioural model of the sequencer's rules. Honors SEQ_LOOP_EN.
`timescale 1ns/1ps
module tb_cache_req_sequencer;
  localparam int ADDR_W  = 10;
  localparam int DATA_W  = 32;
  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 8;
  localparam int IDX_W   = 4;

`ifdef SEQ_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              prog_we = 1'b0;
  logic [IDX_W-1:0]  prog_idx = '0;
  logic              prog_rw = 1'b0;
  logic [ADDR_W-1:0] prog_addr = '0;
  logic [DATA_W-1:0] prog_wdata = '0;
  logic              prog_chk = 1'b0;
  logic [DATA_W-1:0] prog_expect = '0;
  logic [IDX_W:0]    prog_len = '0;
  logic              start = 1'b0;
  logic              hit_miss = 1'b0;
  logic [DATA_W-1:0] Read_Data = '0;
  logic              req_valid, read_write, busy, done, timeout, err_valid;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] write_data;
  logic [7:0]        err_count, pass_count;
  logic [IDX_W-1:0]  first_err_idx;

  cache_req_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .prog_we(prog_we), .prog_idx(prog_idx),
    .prog_rw(prog_rw), .prog_addr(prog_addr), .prog_wdata(prog_wdata),
    .prog_chk(prog_chk), .prog_expect(prog_expect), .prog_len(prog_len),
    .start(start), .hit_miss(hit_miss), .Read_Data(Read_Data),
    .req_valid(req_valid), .read_write(read_write), .address(address),
    .write_data(write_data), .busy(busy), .done(done), .timeout(timeout),
    .err_count(err_count), .first_err_idx(first_err_idx), .err_valid(err_valid),
    .pass_count(pass_count)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Behavioural model state: program copy plus run status
  bit              p_rw    [DEPTH];
  bit [ADDR_W-1:0] p_addr  [DEPTH];
  bit [DATA_W-1:0] p_wd    [DEPTH];
  bit              p_chk   [DEPTH];
  bit [DATA_W-1:0] p_exp   [DEPTH];
  bit m_run = 0, m_done = 0, m_to = 0, m_ev = 0;
  int m_idx = 0, m_len = 0, m_stall = 0, m_err = 0, m_first = 0, m_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare DUT against the model, then advance the model with the inputs the
  // next rising edge will sample (inputs only change just after rising edges).
  initial forever begin
    @(negedge clock);
    if (chk_en) begin
      check("req_valid", 64'(req_valid), 64'(m_run));
      check("busy", 64'(busy), 64'(m_run));
      check("read_write", 64'(read_write), m_run ? 64'(p_rw[m_idx]) : 64'd0);
      check("address", 64'(address), m_run ? 64'(p_addr[m_idx]) : 64'd0);
      check("write_data", 64'(write_data), m_run ? 64'(p_wd[m_idx]) : 64'd0);
      check("done", 64'(done), 64'(m_done));
      check("timeout", 64'(timeout), 64'(m_to));
      check("err_count", 64'(err_count), 64'(m_err));
      check("err_valid", 64'(err_valid), 64'(m_ev));
      check("first_err_idx", 64'(first_err_idx), 64'(m_first));
      check("pass_count", 64'(pass_count), 64'(m_pass));
    end
    if (prog_we && !m_run) begin
      p_rw[prog_idx] = prog_rw;   p_addr[prog_idx] = prog_addr;
      p_wd[prog_idx] = prog_wdata; p_chk[prog_idx] = prog_chk;
      p_exp[prog_idx] = prog_expect;
    end
    if (reset) begin
      m_run = 0; m_done = 0; m_to = 0; m_ev = 0;
      m_idx = 0; m_len = 0; m_stall = 0; m_err = 0; m_first = 0; m_pass = 0;
    end else if (!m_run) begin
      if (start) begin
        m_len = int'(prog_len); m_idx = 0; m_stall = 0; m_to = 0;
        m_err = 0; m_ev = 0; m_first = 0;
        if (m_len == 0) begin m_done = 1; m_pass = LOOP ? 0 : 1; end
        else begin m_done = 0; m_run = 1; m_pass = 0; end
      end
    end else if (LOOP && start) begin
      m_run = 0; m_done = 1; m_to = 0;
    end else if (m_stall == TIMEOUT) begin
      m_run = 0; m_done = 1; m_to = 1;
    end else if (hit_miss) begin
      if (!p_rw[m_idx] && p_chk[m_idx] && Read_Data != p_exp[m_idx]) begin
        if (m_err < 255) m_err++;
        if (!m_ev) begin m_ev = 1; m_first = m_idx; end
      end
      m_stall = 0;
      if (m_idx == m_len - 1) begin
        if (LOOP) begin m_idx = 0; if (m_pass < 255) m_pass++; end
        else begin m_run = 0; m_done = 1; m_pass = 1; end
      end else m_idx++;
    end else begin
      m_stall++;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic prog_entry(input int idx, input bit rw, input int addr, input int wd,
                            input bit chk, input int exp);
    prog_we = 1; prog_idx = IDX_W'(idx); prog_rw = rw; prog_addr = ADDR_W'(addr);
    prog_wdata = DATA_W'(wd); prog_chk = chk; prog_expect = DATA_W'(exp);
    tick();
    prog_we = 0;
  endtask

  task automatic go(input int len);
    prog_len = (IDX_W + 1)'(len); start = 1;
    tick();
    start = 0;
  endtask

  // Respond to the running sequence; period 0 = hit only the first cycle.
  // Entries bad0/bad1 return corrupted read data.
  task automatic run_wait(input int period, input int bad0, input int bad1,
                          input int max, output int ncyc);
    int k;
    k = 0;
    while (busy === 1'b1 && k < max) begin
      hit_miss = (period == 0) ? (k == 0) : ((k % period) == period - 1);
      Read_Data = p_exp[m_idx] ^ ((m_idx == bad0 || m_idx == bad1) ? 32'h5A : 32'h0);
      tick();
      k++;
    end
    hit_miss = 0;
    ncyc = k;
    check("run_bound", 64'(busy), 64'd0);
  endtask

  initial begin
    int n;
    int hp;
    reset = 1;
    tick(); tick();
    check("rst_req_valid", 64'(req_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err_count", 64'(err_count), 64'd0);
    check("rst_pass_count", 64'(pass_count), 64'd0);
    reset = 0;
    chk_en = 1;

    for (int i = 0; i < DEPTH; i++) prog_entry(i, 1'b0, i * 4, 0, 1'b0, 0);
    prog_entry(0, 1'b1, 'h1A8, 'h3ab, 1'b0, 0);
    prog_entry(1, 1'b0, 'h1A8, 0, 1'b1, 'h3ab);
    prog_entry(2, 1'b1, 'h1A8, 'h3ac, 1'b0, 0);
    prog_entry(3, 1'b0, 'h1A8, 0, 1'b1, 'h3ac);
    prog_entry(4, 1'b0, 'h108, 0, 1'b1, 0);

`ifndef SEQ_LOOP_EN
    // Basic run, always hit
    go(5);
    check("first_addr", 64'(address), 64'h1A8);
    check("first_rw", 64'(read_write), 64'd1);
    run_wait(1, -1, -1, 50, n);
    check("basic_cycles", 64'(n), 64'd5);
    check("basic_done", 64'(done), 64'd1);
    check("basic_errs", 64'(err_count), 64'd0);
    check("basic_err_valid", 64'(err_valid), 64'd0);
    check("basic_pass", 64'(pass_count), 64'd1);

    // Three misses before each hit
    go(5);
    run_wait(4, -1, -1, 100, n);
    check("stall_cycles", 64'(n), 64'd20);

    // Mismatches on entries 2 and 4 (entry 2 becomes a checked read)
    prog_entry(2, 1'b0, 'h1A8, 0, 1'b1, 'h3ab);
    go(5);
    run_wait(1, 2, 4, 50, n);
    check("mm_errs", 64'(err_count), 64'd2);
    check("mm_first", 64'(first_err_idx), 64'd2);
    check("mm_err_valid", 64'(err_valid), 64'd1);
    check("mm_done", 64'(done), 64'd1);

    // Stall on entry 1 until timeout
    go(5);
    run_wait(0, -1, -1, 40, n);
    check("to_cycles", 64'(n), 64'd10);
    check("to_timeout", 64'(timeout), 64'd1);
    check("to_done", 64'(done), 64'd1);
    check("to_req_valid", 64'(req_valid), 64'd0);
    check("to_pass", 64'(pass_count), 64'd0);

    // Program write and start on the same edge; then replay
    prog_we = 1; prog_idx = '0; prog_rw = 0; prog_addr = 10'h155; prog_chk = 0;
    prog_len = 1; start = 1;
    tick();
    prog_we = 0; start = 0;
    check("ws_addr", 64'(address), 64'h155);
    check("ws_req_valid", 64'(req_valid), 64'd1);
    run_wait(1, -1, -1, 10, n);
    check("ws_cycles", 64'(n), 64'd1);
    go(1);
    check("replay_addr", 64'(address), 64'h155);
    run_wait(1, -1, -1, 10, n);
    check("replay_done", 64'(done), 64'd1);
`else
    // Continuous replay of three entries, then stop
    go(3);
    hit_miss = 1;
    for (int i = 0; i < 10; i++) begin Read_Data = p_exp[m_idx]; tick(); end
    hit_miss = 0;
    check("loop_pass", 64'(pass_count), 64'd3);
    check("loop_busy", 64'(busy), 64'd1);
    start = 1; tick(); start = 0;
    check("stop_done", 64'(done), 64'd1);
    check("stop_timeout", 64'(timeout), 64'd0);
    check("stop_busy", 64'(busy), 64'd0);
`endif

    // Empty program
    go(0);
    check("len0_done", 64'(done), 64'd1);
    check("len0_req_valid", 64'(req_valid), 64'd0);

    // Reset in the middle of a run
    go(5);
    tick(); tick();
    reset = 1; tick(); reset = 0;
    check("mrst_req_valid", 64'(req_valid), 64'd0);
    check("mrst_busy", 64'(busy), 64'd0);
    check("mrst_address", 64'(address), 64'd0);
    check("mrst_done", 64'(done), 64'd0);
    check("mrst_errs", 64'(err_count), 64'd0);

    // Randomized traffic against the model
    hp = 80;
    for (int c = 0; c < 4000; c++) begin
      prog_we = 0; start = 0; reset = 0;
      if ($urandom_range(0, 3) == 0 || (busy && $urandom_range(0, 1) == 0)) begin
        prog_we = 1; prog_idx = IDX_W'($urandom_range(0, DEPTH - 1));
        prog_rw = 1'($urandom); prog_addr = ADDR_W'($urandom);
        prog_wdata = DATA_W'($urandom); prog_chk = 1'($urandom);
        prog_expect = DATA_W'($urandom_range(0, 3));
      end
      if ((!busy && $urandom_range(0, 4) == 0) || (busy && $urandom_range(0, 40) == 0)) begin
        start = 1;
        prog_len = (IDX_W + 1)'($urandom_range(0, DEPTH));
        case ($urandom_range(0, 2))
          0: hp = 100;
          1: hp = 70;
          default: hp = 8;
        endcase
      end
      if ($urandom_range(0, 499) == 0) reset = 1;
      hit_miss = ($urandom_range(0, 99) < hp);
      Read_Data = ($urandom_range(0, 1) == 1) ? p_exp[m_idx] : DATA_W'($urandom_range(0, 3));
      tick();
    end
    prog_we = 0; start = 0; reset = 0; hit_miss = 0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
